// File: rtl/hub75_scan_ctrl.sv
// hub75_scan_ctrl: binary-code-modulation scan controller for a HUB75 panel.
// Reads bit-planes out of the dual-port pixel RAM, shifts them into the panel,
// and drives latch, row address and output-enable. Plane p is displayed for
// BASE_OE<<p clocks, and the next plane is shifted in while the current one
// is on display.
module hub75_scan_ctrl #(
    parameter int COLS     = 64,
    parameter int ROW_BITS = 4,
    parameter int BITS     = 5,
    parameter int BASE_OE  = 16
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                enable,
    output logic [ROW_BITS+$clog2(COLS)-1:0]    pixel,
    input  logic [15:0]                         ram_rdata1,
    input  logic [15:0]                         ram_rdata2,
    output logic                                hub_r1,
    output logic                                hub_g1,
    output logic                                hub_b1,
    output logic                                hub_r2,
    output logic                                hub_g2,
    output logic                                hub_b2,
    output logic                                hub_clk,
    output logic                                hub_lat,
    output logic                                hub_oe,
    output logic [ROW_BITS-1:0]                 hub_row,
    output logic                                frame_strobe
);

    localparam int COL_BITS = $clog2(COLS);
    localparam int S_LAST   = 2 * COLS + 1;
    localparam int SW       = $clog2(S_LAST + 1);
    localparam int CW       = $clog2((BASE_OE << (BITS - 1)) + 1);
    localparam int PB       = (BITS > 1) ? $clog2(BITS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        BLANK,
        LATCH
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [SW-1:0]       s;
    logic [SW-1:0]       s_inc;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_dec;
    logic [CW-1:0]       cnt_nx;
    logic [ROW_BITS-1:0] shift_row;
    logic [ROW_BITS-1:0] row_adv;
    logic [PB-1:0]       shift_plane;
    logic [PB-1:0]       plane_adv;
    logic [3:0]          bsel;
    logic                last_plane;
    logic                shift_done;

    // Bit 15 of each RAM word carries no colour data.
    logic unused_bits;
    assign unused_bits = ram_rdata1[15] ^ ram_rdata2[15];

    // Next state, display-counter next value and plane/row pointer advance.
    // hub_oe is derived from these so it is registered together with the state.
    always_comb begin
        s_inc      = s + 1'b1;
        shift_done = (s == SW'(S_LAST));
        cnt_dec    = (cnt == '0) ? '0 : cnt - 1'b1;
        last_plane = (shift_plane == PB'(BITS - 1));
        plane_adv  = last_plane ? '0 : shift_plane + 1'b1;
        row_adv    = last_plane ? shift_row + 1'b1 : shift_row;
        bsel       = 4'(5 - BITS) + 4'(shift_plane);
        state_nx   = state;
        cnt_nx     = cnt_dec;
        case (state)
            IDLE:    if (enable) state_nx = SHIFT;
            SHIFT:   if (shift_done && cnt_dec == '0) state_nx = BLANK;
            BLANK:   state_nx = LATCH;
            LATCH: begin
                state_nx = enable ? SHIFT : IDLE;
                cnt_nx   = CW'(BASE_OE) << shift_plane;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Scan sequencer: shift timing, latch/row update, display gating.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            s            <= '0;
            shift_row    <= '0;
            shift_plane  <= '0;
            pixel        <= '0;
            hub_r1       <= 1'b0;
            hub_g1       <= 1'b0;
            hub_b1       <= 1'b0;
            hub_r2       <= 1'b0;
            hub_g2       <= 1'b0;
            hub_b2       <= 1'b0;
            hub_clk      <= 1'b0;
            hub_lat      <= 1'b0;
            hub_oe       <= 1'b1;
            hub_row      <= '0;
            frame_strobe <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            hub_oe       <= !(state_nx == SHIFT && cnt_nx != '0);
            hub_lat      <= 1'b0;
            frame_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        s           <= '0;
                        shift_row   <= '0;
                        shift_plane <= '0;
                        pixel       <= '0;
                    end
                end
                SHIFT: begin
                    // s parks at its last value while waiting for the display
                    // counter; the odd-s action then just keeps hub_clk low.
                    if (!shift_done) s <= s_inc;
                    if (s_inc < SW'(2 * COLS)) pixel <= {shift_row, s_inc[COL_BITS:1]};
                    if (s[0]) begin
                        hub_r1  <= ram_rdata1[bsel + 4'd10];
                        hub_g1  <= ram_rdata1[bsel + 4'd5];
                        hub_b1  <= ram_rdata1[bsel];
                        hub_r2  <= ram_rdata2[bsel + 4'd10];
                        hub_g2  <= ram_rdata2[bsel + 4'd5];
                        hub_b2  <= ram_rdata2[bsel];
                        hub_clk <= 1'b0;
                    end else if (s >= SW'(2)) begin
                        hub_clk <= 1'b1;
                    end
                end
                BLANK: begin
                    hub_lat      <= 1'b1;
                    hub_row      <= shift_row;
                    frame_strobe <= (shift_row == '1) && last_plane;
                end
                LATCH: begin
                    s           <= '0;
                    shift_row   <= row_adv;
                    shift_plane <= plane_adv;
                    pixel       <= {row_adv, COL_BITS'(0)};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Self-checking bench for hub75_scan_ctrl: random pixel RAM, a schedule-level
// reference of the BCM scan, an enable drop/restart and a mid-shift reset.
module tb_hub75_scan_ctrl;

    localparam int COLS     = 4;
    localparam int ROW_BITS = 1;
    localparam int BITS     = 2;
    localparam int BASE_OE  = 16;
    localparam int ROWS     = 1 << ROW_BITS;
    localparam int CB       = $clog2(COLS);
    localparam int PW       = ROW_BITS + CB;
    localparam int NPIX     = ROWS * COLS;

    logic                clock = 1'b0;
    logic                reset;
    logic                enable;
    logic [PW-1:0]       pixel;
    logic [15:0]         ram_rdata1;
    logic [15:0]         ram_rdata2;
    logic                hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2;
    logic                hub_clk, hub_lat, hub_oe, frame_strobe;
    logic [ROW_BITS-1:0] hub_row;

    logic [15:0] mem1 [NPIX];
    logic [15:0] mem2 [NPIX];

    int total = 0;
    int bad   = 0;

    // reference schedule state
    int cyc, t0, vprev, vload, row, plane, exp_row, n_lat, fs_cnt, last_lat, idle_start;
    bit idle, restarted, done;
    logic [COLS-1:0] rseq;

    hub75_scan_ctrl #(
        .COLS    (COLS),
        .ROW_BITS(ROW_BITS),
        .BITS    (BITS),
        .BASE_OE (BASE_OE)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .pixel       (pixel),
        .ram_rdata1  (ram_rdata1),
        .ram_rdata2  (ram_rdata2),
        .hub_r1      (hub_r1),
        .hub_g1      (hub_g1),
        .hub_b1      (hub_b1),
        .hub_r2      (hub_r2),
        .hub_g2      (hub_g2),
        .hub_b2      (hub_b2),
        .hub_clk     (hub_clk),
        .hub_lat     (hub_lat),
        .hub_oe      (hub_oe),
        .hub_row     (hub_row),
        .frame_strobe(frame_strobe)
    );

    always #5 clock = ~clock;

    // dual-port RAM read side, one clock latency
    always @(posedge clock) begin
        ram_rdata1 <= mem1[pixel];
        ram_rdata2 <= mem2[pixel];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pixel"}, 32'(pixel), 0);
        chk({tag, "_row"},   32'(hub_row), 0);
        chk({tag, "_rgb"},   32'({hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2}), 0);
        chk({tag, "_clk"},   32'(hub_clk), 0);
        chk({tag, "_lat"},   32'(hub_lat), 0);
        chk({tag, "_fs"},    32'(frame_strobe), 0);
        chk({tag, "_oe"},    32'(hub_oe), 1);
    endtask

    // Compare one cycle against the plane schedule: a plane shifted from t0
    // latches at t0 + max(2*COLS+2, previous on-time) + 1, and the panel is
    // lit for the first vprev cycles after the previous latch.
    task automatic cycle_check();
        int rel, len, k, b, a;
        bit eclk, elat;
        logic [15:0] w1, w2;
        rel = cyc - t0;
        if (idle) begin
            chk("idle_oe",  32'(hub_oe), 1);
            chk("idle_lat", 32'(hub_lat), 0);
            chk("idle_clk", 32'(hub_clk), 0);
            chk("idle_fs",  32'(frame_strobe), 0);
            chk("idle_row", 32'(hub_row), 32'(exp_row));
            if (enable) begin
                idle  = 1'b0;
                t0    = cyc + 1;
                row   = 0;
                plane = 0;
                vprev = vload - (t0 - last_lat - 1);
                if (vprev < 0) vprev = 0;
            end
        end else begin
            len  = ((2 * COLS + 2 > vprev) ? 2 * COLS + 2 : vprev) + 1;
            elat = (rel == len);
            eclk = (rel >= 3) && (rel <= 2 * COLS + 1) && (rel % 2 == 1);
            chk("oe",  32'(hub_oe), (rel < vprev) ? 0 : 1);
            chk("lat", 32'(hub_lat), 32'(elat));
            chk("clk", 32'(hub_clk), 32'(eclk));
            if (rel < 2 * COLS) chk("pixel", 32'(pixel), row * COLS + rel / 2);
            if (eclk) begin
                k  = (rel - 3) / 2;
                a  = row * COLS + k;
                b  = 5 - BITS + plane;
                w1 = mem1[PW'(a)];
                w2 = mem2[PW'(a)];
                chk("r1", 32'(hub_r1), 32'(w1[4'(10 + b)]));
                chk("g1", 32'(hub_g1), 32'(w1[4'(5 + b)]));
                chk("b1", 32'(hub_b1), 32'(w1[4'(b)]));
                chk("r2", 32'(hub_r2), 32'(w2[4'(10 + b)]));
                chk("g2", 32'(hub_g2), 32'(w2[4'(5 + b)]));
                chk("b2", 32'(hub_b2), 32'(w2[4'(b)]));
                if (n_lat == 0) rseq[CB'(k)] = hub_r1;
            end
            if (elat) exp_row = row;
            chk("row", 32'(hub_row), 32'(exp_row));
            chk("fs", 32'(frame_strobe), 32'(elat && row == ROWS - 1 && plane == BITS - 1));
            if (frame_strobe === 1'b1) fs_cnt++;
            if (elat) begin
                n_lat++;
                vload    = BASE_OE << plane;
                vprev    = vload;
                last_lat = cyc;
                t0       = cyc + 1;
                if (plane == BITS - 1) begin
                    plane = 0;
                    row   = (row + 1) % ROWS;
                end else begin
                    plane++;
                end
                if (!enable) begin
                    idle       = 1'b1;
                    idle_start = cyc + 1;
                end
            end
        end
        cyc++;
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b1;
        cyc = 0; t0 = 0; vprev = 0; vload = 0; row = 0; plane = 0; exp_row = 0;
        n_lat = 0; fs_cnt = 0; last_lat = -1; idle_start = 0;
        idle = 1'b0; restarted = 1'b0; done = 1'b0;
        rseq = '0;
        for (int unsigned i = 0; i < NPIX; i++) begin
            mem1[PW'(i)] = 16'($urandom);
            mem2[PW'(i)] = 16'($urandom);
        end
        for (int unsigned k = 0; k < COLS; k++)
            mem1[PW'(k)] = (k % 2 == 1) ? 16'h7FFF : 16'h0000;

        @(negedge clock);
        chk_reset("rst");
        reset = 1'b0;

        while (!done && cyc < 2000) begin
            @(negedge clock);
            if (!idle && n_lat == 10 && cyc - t0 == 4) enable = 1'b0;
            if (idle && cyc - idle_start == 45) begin
                enable    = 1'b1;
                restarted = 1'b1;
            end
            if (restarted && !idle && n_lat == 12 && cyc - t0 == 5) begin
                cycle_check();
                #2 reset = 1'b1;
                #1 chk_reset("async");
                for (int unsigned i = 0; i < 3; i++) begin
                    @(negedge clock);
                    chk_reset("hold");
                end
                done = 1'b1;
            end else begin
                cycle_check();
            end
        end

        if (!done) chk("timeout", 0, 1);
        chk("r1_seq", 32'(rseq), 32'b1010);
        chk("fs_count", fs_cnt, 2);
        chk("latches", n_lat, 12);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
